// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt pending controller.
package irq_pkg;

    localparam int N_IRQ    = 8;
    localparam int IRQ_ID_W = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // One-hot mask for a presented index, used to clear its pending bit.
    function automatic logic [N_IRQ-1:0] onehot8(input logic [IRQ_ID_W-1:0] id);
        logic [N_IRQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/irq_pending_ctrl_prio_enc8.sv
// Combinational 8-to-3 strict-priority encoder; bit 7 has highest priority.
module prio_enc8
    import irq_pkg::*;
(
    input  logic [N_IRQ-1:0]    req_vec,
    output logic [IRQ_ID_W-1:0] idx,
    output logic                any
);

    // Scan upward so the highest set bit is the last (winning) assignment.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        idx = '0;
        any = |req_vec;
        for (int i = 0; i < N_IRQ; i++) begin
            if (req_vec[i]) begin
                idx = IRQ_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Sticky interrupt pending register with mask, priority selection and a
// valid/ack presentation handshake with an acknowledge timeout.
// Build option: define IRQ_EDGE_EN to capture only rising edges of req
// (default: level capture).
module irq_pending_ctrl
    import irq_pkg::*;
#(
    parameter  int ACK_TIMEOUT = 16,
    localparam int CNT_W       = $clog2(ACK_TIMEOUT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_IRQ-1:0]    req,
    input  logic [N_IRQ-1:0]    mask,
    input  logic                en,
    input  logic                irq_ack,
    output logic                irq_valid,
    output logic [IRQ_ID_W-1:0] irq_id,
    output logic [N_IRQ-1:0]    pending,
    output logic                timeout
);

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [N_IRQ-1:0]      set;
    logic [N_IRQ-1:0]      clr;
    logic [N_IRQ-1:0]      sel;
    logic [IRQ_ID_W-1:0]   enc_idx;
    logic                  enc_any;
    logic                  at_limit;
    logic                  handshake;
    logic                  start;
    logic                  expire;

`ifdef IRQ_EDGE_EN
    logic [N_IRQ-1:0]      req_q;

    // Remember last cycle's request lines for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= '0;
        end else begin
            req_q <= req;
        end
    end

    // Only a 0->1 transition on a line marks it pending.
    always_comb begin
        set = req & ~req_q;
    end
`else
    // Level capture: a high line marks (or keeps) its bit pending.
    always_comb begin
        set = req;
    end
`endif

    assign sel = pending & ~mask;

    prio_enc8 u_enc (
        .req_vec (sel),
        .idx     (enc_idx),
        .any     (enc_any)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start on enabled unmasked work, leave on ack or timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en && enc_any) begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (irq_ack || at_limit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and handshake/timeout qualifiers.
    always_comb begin
        irq_valid = (state_q == PRESENT);
        at_limit  = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
        handshake = irq_valid && irq_ack;
        expire    = irq_valid && !irq_ack && at_limit;
        start     = (state_q == IDLE) && (state_d == PRESENT);
        clr       = handshake ? onehot8(irq_id) : '0;
    end

    // Presented index, ack-wait counter and the one-cycle timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_id  <= '0;
            cnt_q   <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= expire;
            if (start) begin
                irq_id <= enc_idx;
                cnt_q  <= '0;
            end else if (irq_valid && !at_limit) begin
                cnt_q  <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Sticky pending: set takes priority over the ack clear on the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr) | set;
        end
    end

endmodule
